// File: rtl/flappy_pkg.sv
// Shared constants, state encoding and the game-state record for the
// flappy game engine. All geometry is in screen pixels (640x480 frame).
package flappy_pkg;

  // Horizontal geometry (10-bit, pipe_x domain)
  localparam logic [9:0] BIRD_X     = 10'd100;
  localparam logic [9:0] BIRD_SIZE  = 10'd8;
  localparam logic [9:0] PIPE_W     = 10'd40;
  localparam logic [9:0] SCREEN_W   = 10'd640;
  localparam logic [9:0] PIPE_SPEED = 10'd2;
  localparam logic [9:0] SCORE_X    = 10'd60;

  // Vertical geometry (9-bit, bird_y / hole_y domain)
  localparam logic [8:0] GAP_H    = 9'd100;
  localparam logic [8:0] FLOOR_Y  = 9'd472;
  localparam logic [8:0] HOLE_MIN = 9'd40;
  localparam logic [8:0] START_Y  = 9'd240;
  localparam logic [8:0] HOLE_RST = 9'd190;

  // Vertical velocity, pixels per frame
  localparam logic signed [4:0] GRAVITY = 5'sd1;
  localparam logic signed [4:0] FLAP_V  = -5'sd8;
  localparam logic signed [4:0] VEL_MAX = 5'sd8;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  typedef struct packed {
    logic        [8:0] bird_y;
    logic signed [4:0] vel;
    logic        [9:0] pipe_x;
    logic        [8:0] hole_y;
    logic        [7:0] score;
    logic              scored;  // current pipe already counted
  } game_t;

endpackage

// File: rtl/flappy_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free running every clk.
// Ports: clk, rst_n (sync, active low, loads LFSR_SEED), value[7:0].
module flappy_lfsr
  import flappy_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] value
);

  always_ff @(posedge clk) begin
    if (!rst_n) value <= LFSR_SEED;
    else        value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
  end

endmodule

// File: rtl/flappy_game_engine.sv
// Flappy-bird game state engine. Advances once per video frame (vsync rise):
// bird physics, pipe scroll, scoring, collision and IDLE/PLAY/DEAD FSM.
// Ports:
//   clk, rst_n       pixel clock, synchronous active-low reset
//   vsync            vertical sync, active high (frame tick on its rise)
//   flap             flap button level, synchronous to clk
//   bird_y           bird top row (box x 100..107, y bird_y..bird_y+7)
//   hole_y           top row of pipe gap (gap hole_y..hole_y+100)
//   pipe_x           pipe left column (pipe pipe_x..pipe_x+39)
//   score            pipes passed, saturating at 255
//   game_over        high while in DEAD
module flappy_game_engine
  import flappy_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       flap,
  output logic [8:0] bird_y,
  output logic [8:0] hole_y,
  output logic [9:0] pipe_x,
  output logic [7:0] score,
  output logic       game_over
);

  logic   vsync_q, flap_q, pending;
  logic   tick, flap_edge;
  state_t state, state_n;
  game_t  g, g_n, phys, idle_g;
  logic   dies;
  logic [7:0] lfsr;

  assign tick      = vsync & ~vsync_q;
  assign flap_edge = flap & ~flap_q;

  flappy_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .value (lfsr)
  );

  // Round-start values; the gap position carries over from the last round.
  always_comb begin
    idle_g        = g;
    idle_g.bird_y = START_Y;
    idle_g.vel    = '0;
    idle_g.pipe_x = SCREEN_W;
    idle_g.score  = '0;
    idle_g.scored = 1'b0;
  end

  // One frame of play, computed from the current state.
  logic signed [4:0] vel_cur;
  logic signed [9:0] y_sum;
  logic              floor_hit, x_ovl, y_out;

  assign vel_cur = g.vel;

  always_comb begin
    phys      = g;
    floor_hit = 1'b0;

    phys.vel = pending ? FLAP_V :
               (vel_cur >= VEL_MAX) ? VEL_MAX : vel_cur + GRAVITY;

    y_sum = $signed({1'b0, g.bird_y}) + $signed({{5{phys.vel[4]}}, phys.vel});
    if (y_sum < 10'sd0) begin
      phys.bird_y = '0;                       // ceiling is a soft stop
    end else if (y_sum >= $signed({1'b0, FLOOR_Y})) begin
      phys.bird_y = FLOOR_Y;
      floor_hit   = 1'b1;
    end else begin
      phys.bird_y = y_sum[8:0];
    end

    if (g.pipe_x <= PIPE_SPEED) begin
      phys.pipe_x = SCREEN_W;
      phys.hole_y = HOLE_MIN + {1'b0, lfsr};
      phys.scored = 1'b0;
    end else begin
      phys.pipe_x = g.pipe_x - PIPE_SPEED;
    end

    if (phys.pipe_x <= SCORE_X && !phys.scored) begin
      phys.scored = 1'b1;
      if (g.score != 8'hFF) phys.score = g.score + 8'd1;
    end

    // Collision on post-update positions; a score on the same frame still counts.
    x_ovl = (phys.pipe_x < BIRD_X + BIRD_SIZE) &&
            ({1'b0, phys.pipe_x} + {1'b0, PIPE_W} > {1'b0, BIRD_X});
    y_out = (phys.bird_y < phys.hole_y) ||
            ({1'b0, phys.bird_y} + (BIRD_SIZE - 10'd1) > {1'b0, phys.hole_y} + {1'b0, GAP_H});
    dies  = floor_hit || (x_ovl && y_out);
  end

  // Next-state / next-game selection, gated by the frame tick.
  always_comb begin
    state_n = state;
    g_n     = g;
    if (tick) begin
      unique case (state)
        ST_IDLE: if (pending) begin
          g_n     = phys;
          state_n = dies ? ST_DEAD : ST_PLAY;
        end
        ST_PLAY: begin
          g_n     = phys;
          state_n = dies ? ST_DEAD : ST_PLAY;
        end
        ST_DEAD: if (pending) begin
          g_n     = idle_g;
          state_n = ST_IDLE;
        end
        default: begin
          g_n     = idle_g;
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q   <= 1'b0;
      flap_q    <= 1'b0;
      pending   <= 1'b0;
      state     <= ST_IDLE;
      g         <= '{bird_y: START_Y, vel: '0, pipe_x: SCREEN_W,
                     hole_y: HOLE_RST, score: '0, scored: 1'b0};
      game_over <= 1'b0;
    end else begin
      vsync_q   <= vsync;
      flap_q    <= flap;
      // A press landing on the tick itself is kept for the next frame.
      pending   <= tick ? flap_edge : (pending | flap_edge);
      state     <= state_n;
      g         <= g_n;
      game_over <= (state_n == ST_DEAD);
    end
  end

  assign bird_y = g.bird_y;
  assign hole_y = g.hole_y;
  assign pipe_x = g.pipe_x;
  assign score  = g.score;

endmodule

// File: tb/tb_flappy_game_engine.sv
// Scoreboard bench for flappy_game_engine: stimulus pushes hand-computed
// expected outputs into a queue, a negedge monitor pops and compares.
module tb_flappy_game_engine;

  logic       clk = 1'b0;
  logic       rst_n, vsync, flap;
  logic [8:0] bird_y, hole_y;
  logic [9:0] pipe_x;
  logic [7:0] score;
  logic       game_over;

  always #5 clk = ~clk;

  flappy_game_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync     (vsync),
    .flap      (flap),
    .bird_y    (bird_y),
    .hole_y    (hole_y),
    .pipe_x    (pipe_x),
    .score     (score),
    .game_over (game_over)
  );

  typedef struct {
    string name;
    int    by, hy, px, sc, go;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference LFSR from the polynomial, used only to predict new gap rows.
  logic [7:0] lfsr_m;
  logic [7:0] tick_lfsr;
  always @(posedge clk) begin
    if (!rst_n) lfsr_m <= 8'hA5;
    else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [36:0] got, want;
      e    = sb.pop_front();
      got  = {bird_y, hole_y, pipe_x, score, game_over};
      want = {e.by[8:0], e.hy[8:0], e.px[9:0], e.sc[7:0], e.go[0]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got bird_y=%0d hole_y=%0d pipe_x=%0d score=%0d game_over=%0d, want %0d %0d %0d %0d %0d",
                 e.name, bird_y, hole_y, pipe_x, score, game_over, e.by, e.hy, e.px, e.sc, e.go);
      end
    end
  end

  task automatic chk(input string name, input int by, input int hy, input int px,
                     input int sc, input int go);
    exp_t e;
    e = '{name: name, by: by, hy: hy, px: px, sc: sc, go: go};
    sb.push_back(e);
    @(negedge clk);
  endtask

  // One video frame: optional flap press (or two), then a vsync pulse.
  task automatic frame(input bit f, input bit dbl);
    if (f) begin
      @(negedge clk) flap = 1'b1;
      @(negedge clk) flap = 1'b0;
      if (dbl) begin
        @(negedge clk) flap = 1'b1;
        @(negedge clk) flap = 1'b0;
      end
    end
    @(negedge clk) begin vsync = 1'b1; tick_lfsr = lfsr_m; end
    @(negedge clk) vsync = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int new_hole;
    rst_n = 1'b0; vsync = 1'b0; flap = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", 240, 190, 640, 0, 0);
    rst_n = 1'b1;

    // Idle, then a full fall to the floor with no further flaps
    repeat (3) frame(0, 0);
    chk("idle_hold", 240, 190, 640, 0, 0);
    frame(1, 0);                      chk("flap_start", 232, 190, 638, 0, 0);
    frame(0, 0);                      chk("grav_1",     225, 190, 636, 0, 0);
    repeat (7) frame(0, 0);           chk("vel_zero",   204, 190, 622, 0, 0);
    repeat (8) frame(0, 0);           chk("vel_max",    240, 190, 606, 0, 0);
    frame(0, 0);                      chk("vel_capped", 248, 190, 604, 0, 0);
    repeat (27) frame(0, 0);          chk("pre_floor",  464, 190, 550, 0, 0);
    frame(0, 0);                      chk("floor_dead", 472, 190, 548, 0, 1);
    repeat (3) frame(0, 0);           chk("dead_freeze",472, 190, 548, 0, 1);
    frame(1, 0);                      chk("dead_to_idle",240,190, 640, 0, 0);
    repeat (2) frame(0, 0);           chk("idle_again", 240, 190, 640, 0, 0);

    // Double press in one frame counts once and is not carried over
    frame(1, 0);                      chk("b_play",     232, 190, 638, 0, 0);
    frame(1, 1);                      chk("dbl_flap",   224, 190, 636, 0, 0);
    frame(0, 0);                      chk("no_carry",   217, 190, 634, 0, 0);

    // Reset mid-play, colliding with a tick and a flap press
    @(negedge clk) begin rst_n = 1'b0; vsync = 1'b1; flap = 1'b1; end
    @(negedge clk) begin rst_n = 1'b1; vsync = 1'b0; flap = 1'b0; end
    chk("mid_reset", 240, 190, 640, 0, 0);

    // Full pipe pass: flap every 17 frames keeps bird between 204 and 240
    new_hole = 0;
    for (int n = 1; n <= 321; n++) begin
      frame(((n - 1) % 17) == 0, 0);
      if (n == 320) new_hole = 40 + int'(tick_lfsr);
      case (n)
        1:   chk("pass_start", 232, 190, 638, 0, 0);
        289: chk("pre_score",  240, 190,  62, 0, 0);
        290: chk("score_at60", 232, 190,  60, 1, 0);
        291: chk("score_once", 225, 190,  58, 1, 0);
        300: chk("score_hold", 207, 190,  40, 1, 0);
        319: chk("pipe_at2",   214, 190,   2, 1, 0);
        320: chk("reload",     219, new_hole, 640, 1, 0);
        321: chk("after_rel",  225, new_hole, 638, 1, 0);
        default: ;
      endcase
    end

    // Collision with hole at 190: bird steered to 150 when pipe_x hits 106
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    chk("reset2", 240, 190, 640, 0, 0);
    for (int n = 1; n <= 277; n++) begin
      frame((n <= 228) || (n == 263), 0);
      case (n)
        30:  chk("ceiling",  0,   190, 580, 0, 0);
        244: chk("freefall", 36,  190, 152, 0, 0);
        262: chk("apex",     180, 190, 116, 0, 0);
        266: chk("no_hit",   154, 190, 108, 0, 0);
        267: chk("hit",      150, 190, 106, 0, 1);
        default: if (n > 267) chk("hit_freeze", 150, 190, 106, 0, 1);
      endcase
    end

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
